// File: rtl/pe_pkg.sv
// Shared definitions for the PE front-end: IFMAP word layout and feeder FSM states.
// The IFMAP word is {start_bit, end_bit, data}; bit positions assume the default element width.
package pe_pkg;
  localparam int ELEM_W_DEFAULT  = 16;
  localparam int LEN_W_DEFAULT   = 8;
  localparam int IFMAP_START_BIT = ELEM_W_DEFAULT + 1;
  localparam int IFMAP_END_BIT   = ELEM_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/ifmap_row_feeder_out_reg.sv
// One-entry valid/ready output register: 1-cycle latency, full throughput via same-cycle reload.
// Word holds when the sink is not ready; dout keeps the last loaded value after it is consumed.
module feeder_out_reg #(
  parameter int WIDTH = pe_pkg::ELEM_W_DEFAULT + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             wen
);
  assign wen = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (clear)
        out_valid <= 1'b0;
      else if (load)
        out_valid <= 1'b1;
      else if (wen)
        out_valid <= 1'b0;

      if (load)
        dout <= din;
    end
  end
endmodule

// File: rtl/ifmap_row_feeder.sv
// Tags source elements with row start/end flags and writes them to the PE IFMAP buffer.
// Latency 1 cycle; src_ready drops in the same cycle the IFMAP buffer stalls a pending word.
module ifmap_row_feeder #(
  parameter int ELEMENT_WIDTH = pe_pkg::ELEM_W_DEFAULT,
  parameter int LEN_WIDTH     = pe_pkg::LEN_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     row_len,
  input  logic [LEN_WIDTH-1:0]     num_rows,
  input  logic                     flush,
  input  logic                     src_valid,
  input  logic [ELEMENT_WIDTH-1:0] src_data,
  output logic                     src_ready,
  input  logic                     ifmap_ready,
  output logic                     ifmap_wen,
  output logic [ELEMENT_WIDTH+1:0] ifmap_din,
  output logic                     busy,
  output logic                     done
);
  import pe_pkg::*;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  feeder_state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] row_len_q, num_rows_q, col_cnt, row_cnt;
  logic out_valid, accept, col_last, row_last, job_ok, done_nxt;
  logic [ELEMENT_WIDTH+1:0] word;

  assign job_ok    = (row_len != '0) && (num_rows != '0);
  assign col_last  = (col_cnt == row_len_q - LEN_ONE);
  assign row_last  = (row_cnt == num_rows_q - LEN_ONE);
  assign src_ready = (state == STREAM) & (!out_valid | ifmap_ready) & !flush;
  assign accept    = src_valid & src_ready;
  assign busy      = (state != IDLE);
  assign word      = {(col_cnt == '0), col_last, src_data};

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // An empty job completes immediately without touching the source.
            if (job_ok)
              state_nxt = STREAM;
            else
              done_nxt = 1'b1;
          end
        end
        STREAM: begin
          if (accept && col_last && row_last)
            state_nxt = DRAIN;
        end
        DRAIN: begin
          if (ifmap_wen) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else if (flush) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (state == IDLE && start) begin
      row_len_q  <= row_len;
      num_rows_q <= num_rows;
      col_cnt    <= '0;
      row_cnt    <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + LEN_ONE;
      end else begin
        col_cnt <= col_cnt + LEN_ONE;
      end
    end
  end

  feeder_out_reg #(
    .WIDTH(ELEMENT_WIDTH + 2)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .load     (accept),
    .din      (word),
    .out_ready(ifmap_ready),
    .out_valid(out_valid),
    .dout     (ifmap_din),
    .wen      (ifmap_wen)
  );
endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Bench for ifmap_row_feeder: directed jobs plus randomized valid/ready traffic against a word-list model.
module tb_ifmap_row_feeder;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  row_len = '0;
  logic [7:0]  num_rows = '0;
  logic        flush = 1'b0;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_ready;
  logic        ifmap_ready = 1'b0;
  logic        ifmap_wen;
  logic [17:0] ifmap_din;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  ifmap_row_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .row_len    (row_len),
    .num_rows   (num_rows),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .ifmap_ready(ifmap_ready),
    .ifmap_wen  (ifmap_wen),
    .ifmap_din  (ifmap_din),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // abort_mode: 0 none, 1 flush, 2 async reset; taken once abort_after words are written.
  task automatic run_job(input int len, input int rows, input int vprob, input int rprob,
                         input bit seq, input int stall_after, input int stall_len,
                         input int abort_mode, input int abort_after);
    logic [15:0] src_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] w;
    logic [15:0] d;
    int n, wr_cnt, done_cnt, done_cyc, first_wr, last_wr, stall_left;
    bit acc, stalled_now, fast;
    n = len * rows;
    wr_cnt = 0; done_cnt = 0; done_cyc = -10; first_wr = -1; last_wr = -1;
    stall_left = stall_len; stalled_now = 0;
    fast = (vprob == 100) && (rprob == 100) && (stall_len == 0) && (abort_mode == 0);
    for (int i = 0; i < n; i++) begin
      d = seq ? 16'(i + 1) : 16'($urandom);
      src_q.push_back(d);
      w = '0;
      w[IFMAP_START_BIT] = ((i % len) == 0);
      w[IFMAP_END_BIT]   = ((i % len) == (len - 1));
      w[15:0] = d;
      exp_q.push_back(w);
    end

    @(posedge clk); #1;
    start = 1'b1; row_len = 8'(len); num_rows = 8'(rows);
    src_valid = 1'b0; ifmap_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    row_len = 8'($urandom); num_rows = 8'($urandom);
    src_valid = ($urandom_range(99) < vprob);
    src_data = src_q[0];
    ifmap_ready = ($urandom_range(99) < rprob);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("busy_in_job", 32'(busy), 32'd1);
      if (stalled_now) begin
        chk("stall_src_ready", 32'(src_ready), 32'd0);
        chk("stall_din_frozen", 32'(ifmap_din), 32'(exp_q[0]));
      end
      if (ifmap_wen) begin
        if (exp_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
        else begin
          w = exp_q.pop_front();
          chk("word", 32'(ifmap_din), 32'(w));
        end
        wr_cnt++;
        last_wr = cyc;
        if (first_wr < 0) first_wr = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 2) break;
      acc = src_valid & src_ready;

      if (abort_mode != 0 && wr_cnt == abort_after) begin
        @(posedge clk); #1;
        if (abort_mode == 1) begin
          flush = 1'b1; ifmap_ready = 1'b0;
          @(negedge clk);
          chk("flush_src_ready", 32'(src_ready), 32'd0);
          @(posedge clk); #1;
          flush = 1'b0; ifmap_ready = 1'b1; src_valid = 1'b1;
          @(negedge clk);
          chk("flush_busy", 32'(busy), 32'd0);
          chk("flush_wen", 32'(ifmap_wen), 32'd0);
          chk("flush_src_ready_after", 32'(src_ready), 32'd0);
          chk("flush_no_done", 32'(done), 32'd0);
          @(negedge clk);
          chk("flush_no_done_late", 32'(done), 32'd0);
        end else begin
          rst = 1'b0;
          #1;
          chk("rst_wen", 32'(ifmap_wen), 32'd0);
          chk("rst_src_ready", 32'(src_ready), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_din", 32'(ifmap_din), 32'd0);
          @(posedge clk); #1;
          rst = 1'b1;
          @(negedge clk);
          chk("rst_busy_after", 32'(busy), 32'd0);
        end
        src_valid = 1'b0;
        return;
      end

      @(posedge clk); #1;
      if (acc) void'(src_q.pop_front());
      src_valid = (src_q.size() > 0) && ($urandom_range(99) < vprob);
      src_data = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
      stalled_now = 0;
      if (wr_cnt >= stall_after && stall_left > 0) begin
        ifmap_ready = 1'b0;
        stall_left--;
        stalled_now = 1;
      end else begin
        ifmap_ready = ($urandom_range(99) < rprob);
      end
    end

    src_valid = 1'b0;
    chk("write_count", 32'(wr_cnt), 32'(n));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    chk("done_after_last_write", 32'(done_cyc), 32'(last_wr + 1));
    chk("busy_after_job", 32'(busy), 32'd0);
    if (fast) chk("back_to_back", 32'(last_wr - first_wr), 32'(n - 1));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_wen", 32'(ifmap_wen), 32'd0);
    chk("reset_din", 32'(ifmap_din), 32'd0);
    chk("reset_src_ready", 32'(src_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic two-row job at full rate, then single-element rows.
    run_job(3, 2, 100, 100, 1, 0, 0, 0, 0);
    run_job(1, 3, 100, 100, 1, 0, 0, 0, 0);
    // Four-cycle sink stall after the second word.
    run_job(3, 2, 100, 100, 1, 2, 4, 0, 0);

    // Empty jobs: done next cycle, nothing else moves.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; row_len = (k == 0) ? 8'd0 : 8'd3; num_rows = (k == 0) ? 8'd2 : 8'd0;
      src_valid = 1'b1; ifmap_ready = 1'b1;
      @(negedge clk);
      chk("empty_done_early", 32'(done), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_busy_next", 32'(busy), 32'd0);
      chk("empty_src_ready", 32'(src_ready), 32'd0);
      chk("empty_wen", 32'(ifmap_wen), 32'd0);
      @(negedge clk);
      chk("empty_done_once", 32'(done), 32'd0);
      src_valid = 1'b0;
    end

    // Flush mid-job, then a clean restart.
    run_job(3, 2, 100, 100, 1, 0, 0, 1, 4);
    run_job(3, 2, 100, 100, 1, 0, 0, 0, 0);
    // Async reset mid-job, then a clean restart.
    run_job(3, 2, 100, 100, 1, 0, 0, 2, 3);
    run_job(3, 2, 100, 100, 1, 0, 0, 0, 0);

    // Random shapes and random valid/ready on both sides.
    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(5, 1)), int'($urandom_range(4, 1)), 60, 60, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
